pc_sequencer: RTL and testbench

//  Program-counter stage of the single-cycle MIPS datapath; drives the instruction-memory address.

---
 rtl/mips_defs.sv | 17 +
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_next_mux.sv | 39 +++
 rtl/pc_sequencer.sv | 65 ++++++
 tb/tb_pc_sequencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the MIPS program-counter slice.
//   PC_SEL_*     : next-PC select encodings, {s1,s0} as on the datapath 4:1 mux
//   ST_RUN/HALT  : sequencer FSM state encodings
//   RESET_VECTOR_DEF : default PC value loaded on reset
package mips_defs;

   localparam logic [1:0] PC_SEL_SEQ = 2'b00;
   localparam logic [1:0] PC_SEL_BR  = 2'b01;
   localparam logic [1:0] PC_SEL_J   = 2'b10;
   localparam logic [1:0] PC_SEL_JR  = 2'b11;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus bundle between the control/datapath side and the PC sequencer.
//   master : drives stall, pc_sel, branch_taken, imm_sext, jump_idx, rs_data,
//            halt_req, resume; observes pc, pc_plus4, halted, misaligned, retired_cnt
//   slave  : the PC sequencer (mirror of master)
interface pc_sequencer_if #(
   parameter int unsigned CNT_W = 32
);

   logic             stall;
   logic [1:0]       pc_sel;
   logic             branch_taken;
   logic [31:0]      imm_sext;
   logic [25:0]      jump_idx;
   logic [31:0]      rs_data;
   logic             halt_req;
   logic             resume;
   logic [31:0]      pc;
   logic [31:0]      pc_plus4;
   logic             halted;
   logic             misaligned;
   logic [CNT_W-1:0] retired_cnt;

   modport master (
      output stall, pc_sel, branch_taken, imm_sext, jump_idx, rs_data,
             halt_req, resume,
      input  pc, pc_plus4, halted, misaligned, retired_cnt
   );

   modport slave (
      input  stall, pc_sel, branch_taken, imm_sext, jump_idx, rs_data,
             halt_req, resume,
      output pc, pc_plus4, halted, misaligned, retired_cnt
   );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selector.
//   pc_plus4     in  32  current pc + 4
//   pc_sel       in  2   00 seq, 01 branch, 10 jump, 11 jr
//   branch_taken in  1   qualifies the branch select
//   imm_sext     in  32  sign-extended word offset
//   jump_idx     in  26  J-type index
//   rs_data      in  32  jr target register
//   next_pc      out 32  selected next PC
//   jr_misalign  out 1   jr selected and target has low bits set
module pc_next_mux
   import mips_defs::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [1:0]  pc_sel,
   input  logic        branch_taken,
   input  logic [31:0] imm_sext,
   input  logic [25:0] jump_idx,
   input  logic [31:0] rs_data,
   output logic [31:0] next_pc,
   output logic        jr_misalign
);

   always_comb begin
      next_pc     = pc_plus4;
      jr_misalign = 1'b0;
      case (pc_sel)
         PC_SEL_SEQ: next_pc = pc_plus4;
         PC_SEL_BR:  next_pc = branch_taken ? (pc_plus4 + (imm_sext << 2)) : pc_plus4;
         PC_SEL_J:   next_pc = {pc_plus4[31:28], jump_idx, 2'b00};
         PC_SEL_JR: begin
            // Target is forced word-aligned; the flag reports the dropped bits.
            next_pc     = {rs_data[31:2], 2'b00};
            jr_misalign = (rs_data[1:0] != 2'b00);
         end
         default:    next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: registers the selected next PC, handles stall,
// halt/resume, sticky jr misalignment, and counts retired instructions.
//   clk  in  1  rising-edge clock
//   rst  in  1  synchronous active-high reset
//   bus  slave modport of pc_sequencer_if (control inputs, PC/status outputs)
module pc_sequencer
   import mips_defs::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter int unsigned CNT_W        = 32
) (
   input  logic           clk,
   input  logic           rst,
   pc_sequencer_if.slave  bus
);

   logic [0:0]       state;
   logic [31:0]      pc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             mis_q;
   logic [31:0]      pc_plus4;
   logic [31:0]      next_pc;
   logic             jr_misalign;

   assign pc_plus4 = pc_q + 32'd4;

   pc_next_mux u_next (
      .pc_plus4     (pc_plus4),
      .pc_sel       (bus.pc_sel),
      .branch_taken (bus.branch_taken),
      .imm_sext     (bus.imm_sext),
      .jump_idx     (bus.jump_idx),
      .rs_data      (bus.rs_data),
      .next_pc      (next_pc),
      .jr_misalign  (jr_misalign)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
         pc_q  <= RESET_VECTOR;
         cnt_q <= '0;
         mis_q <= 1'b0;
      end else if (state == ST_HALT) begin
         // resume outranks a simultaneous halt_req
         if (bus.resume)
            state <= ST_RUN;
      end else if (!bus.stall) begin
         // A halt request lets the current instruction retire before stopping.
         pc_q  <= next_pc;
         cnt_q <= cnt_q + 1'b1;
         if (jr_misalign)
            mis_q <= 1'b1;
         if (bus.halt_req)
            state <= ST_HALT;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_plus4;
   assign bus.halted      = (state == ST_HALT);
   assign bus.misaligned  = mis_q;
   assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [1:0]  pc_sel;
   logic        branch_taken;
   logic [31:0] imm_sext;
   logic [25:0] jump_idx;
   logic [31:0] rs_data;
   logic        halt_req;
   logic        resume;

   int vectors = 0;
   int errs    = 0;

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   int          m_cnt4;
   logic        m_mis;
   logic        m_halt;

   always #5 clk = ~clk;

   pc_sequencer_if #(.CNT_W(32)) bus32 ();
   pc_sequencer_if #(.CNT_W(4))  bus4 ();

   assign bus32.stall = stall;          assign bus4.stall = stall;
   assign bus32.pc_sel = pc_sel;        assign bus4.pc_sel = pc_sel;
   assign bus32.branch_taken = branch_taken; assign bus4.branch_taken = branch_taken;
   assign bus32.imm_sext = imm_sext;    assign bus4.imm_sext = imm_sext;
   assign bus32.jump_idx = jump_idx;    assign bus4.jump_idx = jump_idx;
   assign bus32.rs_data = rs_data;      assign bus4.rs_data = rs_data;
   assign bus32.halt_req = halt_req;    assign bus4.halt_req = halt_req;
   assign bus32.resume = resume;        assign bus4.resume = resume;

   pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus32)
   );

   pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .CNT_W(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   task automatic idle();
      rst = 1'b0; stall = 1'b0; pc_sel = 2'b00; branch_taken = 1'b0;
      imm_sext = '0; jump_idx = '0; rs_data = '0; halt_req = 1'b0; resume = 1'b0;
   endtask

   // Advance one clock; the model takes the architectural step implied by the
   // inputs currently applied.
   task automatic tick();
      logic [31:0] npc;
      if (rst) begin
         m_pc = 32'h0; m_cnt = 0; m_cnt4 = 0; m_mis = 0; m_halt = 0;
      end else if (m_halt) begin
         if (resume) m_halt = 0;
      end else if (!stall) begin
         case (pc_sel)
            2'd0: npc = m_pc + 4;
            2'd1: npc = branch_taken ? m_pc + 4 + imm_sext * 4 : m_pc + 4;
            2'd2: npc = ((m_pc + 4) & 32'hF000_0000) | (32'(jump_idx) * 4);
            default: begin
               npc = rs_data & ~32'h3;
               if (rs_data % 4 != 0) m_mis = 1;
            end
         endcase
         m_pc   = npc;
         m_cnt  = m_cnt + 1;
         m_cnt4 = (m_cnt4 + 1) % 16;
         if (halt_req) m_halt = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle(); rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic goto_pc(input logic [31:0] target);
      idle(); pc_sel = 2'b11; rs_data = target; tick(); idle();
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (bus32.pc !== 32'h0) begin $display("FAIL reset_pc got %h exp %h", bus32.pc, 32'h0); errs++; end
      vectors++; if (bus32.retired_cnt !== 32'd0) begin $display("FAIL reset_cnt got %0d exp 0", bus32.retired_cnt); errs++; end
      vectors++; if (bus32.halted !== 1'b0 || bus32.misaligned !== 1'b0) begin $display("FAIL reset_flags got h=%b m=%b exp 0 0", bus32.halted, bus32.misaligned); errs++; end
   endtask

   task automatic test_sequential();
      logic [31:0] exp;
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         tick();
         exp = 32'(i * 4);
         vectors++; if (bus32.pc !== exp) begin $display("FAIL seq_pc step %0d got %h exp %h", i, bus32.pc, exp); errs++; end
      end
      vectors++; if (bus32.retired_cnt !== 32'd4) begin $display("FAIL seq_cnt got %0d exp 4", bus32.retired_cnt); errs++; end
      vectors++; if (bus32.pc_plus4 !== 32'h14) begin $display("FAIL seq_pc_plus4 got %h exp 14", bus32.pc_plus4); errs++; end
   endtask

   task automatic test_branch();
      goto_pc(32'h10);
      pc_sel = 2'b01; branch_taken = 1'b1; imm_sext = 32'hFFFF_FFFE; tick(); idle();
      vectors++; if (bus32.pc !== 32'h0C) begin $display("FAIL br_taken got %h exp 0000000c", bus32.pc); errs++; end
      goto_pc(32'h10);
      pc_sel = 2'b01; branch_taken = 1'b0; imm_sext = 32'hFFFF_FFFE; tick(); idle();
      vectors++; if (bus32.pc !== 32'h14) begin $display("FAIL br_not_taken got %h exp 00000014", bus32.pc); errs++; end
   endtask

   task automatic test_jump_jr();
      do_reset();
      goto_pc(32'h1000_0000);
      pc_sel = 2'b10; jump_idx = 26'h40; tick(); idle();
      vectors++; if (bus32.pc !== 32'h1000_0100) begin $display("FAIL jump got %h exp 10000100", bus32.pc); errs++; end
      vectors++; if (bus32.misaligned !== 1'b0) begin $display("FAIL jr_aligned_flag got %b exp 0", bus32.misaligned); errs++; end
      pc_sel = 2'b11; rs_data = 32'h0000_0203; tick(); idle();
      vectors++; if (bus32.pc !== 32'h200) begin $display("FAIL jr_pc got %h exp 00000200", bus32.pc); errs++; end
      vectors++; if (bus32.misaligned !== 1'b1) begin $display("FAIL jr_misaligned got %b exp 1", bus32.misaligned); errs++; end
      tick(); tick();
      vectors++; if (bus32.misaligned !== 1'b1) begin $display("FAIL misaligned_sticky got %b exp 1", bus32.misaligned); errs++; end
   endtask

   task automatic test_stall_halt();
      do_reset();
      tick(); tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      vectors++; if (bus32.pc !== 32'h8 || bus32.retired_cnt !== 32'd2) begin $display("FAIL stall_hold got pc=%h cnt=%0d exp pc=8 cnt=2", bus32.pc, bus32.retired_cnt); errs++; end
      // stall outranks halt_req
      halt_req = 1'b1; tick();
      vectors++; if (bus32.halted !== 1'b0 || bus32.pc !== 32'h8) begin $display("FAIL stall_over_halt got h=%b pc=%h exp 0 8", bus32.halted, bus32.pc); errs++; end
      stall = 1'b0; tick(); idle();
      vectors++; if (bus32.pc !== 32'hC || bus32.halted !== 1'b1) begin $display("FAIL halt_entry got pc=%h h=%b exp c 1", bus32.pc, bus32.halted); errs++; end
      for (int i = 0; i < 5; i++) tick();
      vectors++; if (bus32.pc !== 32'hC || bus32.retired_cnt !== 32'd3 || bus32.halted !== 1'b1) begin $display("FAIL halt_hold got pc=%h cnt=%0d h=%b exp c 3 1", bus32.pc, bus32.retired_cnt, bus32.halted); errs++; end
      resume = 1'b1; halt_req = 1'b1; tick(); idle();
      vectors++; if (bus32.halted !== 1'b0 || bus32.pc !== 32'hC) begin $display("FAIL resume got h=%b pc=%h exp 0 c", bus32.halted, bus32.pc); errs++; end
      tick();
      vectors++; if (bus32.pc !== 32'h10 || bus32.retired_cnt !== 32'd4) begin $display("FAIL post_resume got pc=%h cnt=%0d exp 10 4", bus32.pc, bus32.retired_cnt); errs++; end
   endtask

   task automatic test_reset_in_halt();
      do_reset();
      tick();
      pc_sel = 2'b11; rs_data = 32'h0000_0101; halt_req = 1'b1; tick(); idle();
      vectors++; if (bus32.halted !== 1'b1 || bus32.misaligned !== 1'b1) begin $display("FAIL pre_rst got h=%b m=%b exp 1 1", bus32.halted, bus32.misaligned); errs++; end
      rst = 1'b1; tick(); rst = 1'b0;
      vectors++; if (bus32.pc !== 32'h0 || bus32.halted !== 1'b0 || bus32.misaligned !== 1'b0 || bus32.retired_cnt !== 32'd0) begin
         $display("FAIL rst_in_halt got pc=%h h=%b m=%b cnt=%0d exp 0 0 0 0", bus32.pc, bus32.halted, bus32.misaligned, bus32.retired_cnt); errs++; end
   endtask

   task automatic test_wrap();
      do_reset();
      goto_pc(32'hFFFF_FFFC);
      vectors++; if (bus32.pc_plus4 !== 32'h0) begin $display("FAIL pc_plus4_wrap got %h exp 0", bus32.pc_plus4); errs++; end
      tick();
      vectors++; if (bus32.pc !== 32'h0) begin $display("FAIL pc_wrap got %h exp 0", bus32.pc); errs++; end
      do_reset();
      for (int i = 0; i < 15; i++) tick();
      vectors++; if (bus4.retired_cnt !== 4'd15) begin $display("FAIL cnt4_max got %0d exp 15", bus4.retired_cnt); errs++; end
      tick();
      vectors++; if (bus4.retired_cnt !== 4'd0) begin $display("FAIL cnt4_wrap got %0d exp 0", bus4.retired_cnt); errs++; end
   endtask

   task automatic test_random();
      logic [31:0] r;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst          = ($urandom_range(0, 59) == 0);
         stall        = ($urandom_range(0, 3) == 0);
         pc_sel       = 2'($urandom_range(0, 3));
         branch_taken = 1'($urandom_range(0, 1));
         r            = $urandom;
         imm_sext     = {{16{r[15]}}, r[15:0]};
         jump_idx     = 26'($urandom);
         rs_data      = $urandom;
         if ($urandom_range(0, 3) != 0) rs_data[1:0] = 2'b00;
         halt_req     = ($urandom_range(0, 7) == 0);
         resume       = ($urandom_range(0, 2) == 0);
         tick();
         vectors++; if (bus32.pc !== m_pc) begin $display("FAIL rnd_pc cyc %0d got %h exp %h", i, bus32.pc, m_pc); errs++; end
         vectors++; if (bus32.pc_plus4 !== m_pc + 32'd4) begin $display("FAIL rnd_pc_plus4 cyc %0d got %h exp %h", i, bus32.pc_plus4, m_pc + 32'd4); errs++; end
         vectors++; if (bus32.halted !== m_halt) begin $display("FAIL rnd_halted cyc %0d got %b exp %b", i, bus32.halted, m_halt); errs++; end
         vectors++; if (bus32.misaligned !== m_mis) begin $display("FAIL rnd_misaligned cyc %0d got %b exp %b", i, bus32.misaligned, m_mis); errs++; end
         vectors++; if (bus32.retired_cnt !== m_cnt) begin $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", i, bus32.retired_cnt, m_cnt); errs++; end
         vectors++; if (bus4.retired_cnt !== 4'(m_cnt4)) begin $display("FAIL rnd_cnt4 cyc %0d got %0d exp %0d", i, bus4.retired_cnt, m_cnt4); errs++; end
      end
      idle();
   endtask

   initial begin
      idle();
      m_pc = '0; m_cnt = '0; m_cnt4 = 0; m_mis = 1'b0; m_halt = 1'b0;
      @(negedge clk);
      test_reset();
      test_sequential();
      test_branch();
      test_jump_jr();
      test_stall_halt();
      test_reset_in_halt();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
